// File: rtl/lfsr_checker_if.sv
// Serial PRBS stream between a generator (master) and the checker (slave).
// Latency: none, this is wiring only.
// Backpressure: none. The receiver must take every beat that is flagged in_valid.
//
// Signals:
//   in_bit    serial data bit
//   in_valid  in_bit carries a beat this cycle
interface lfsr_checker_if;
  logic in_bit;
  logic in_valid;

  modport master (output in_bit, output in_valid);
  modport slave  (input  in_bit, input  in_valid);
endinterface

// File: rtl/lfsr_checker.sv
// PRBS receive checker. It seeds itself from the first WIDTH beats, then predicts each
//   following bit and counts the bits that do not match.
// Latency: locked, bit_err, err_count and hist_state update on the edge that samples the beat.
// Backpressure: none. Every in_valid beat is consumed. resync discards the beat that comes with it.
//
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   taps            feedback mask, same encoding as the generator
//   s (slave)       serial stream: in_bit / in_valid
//   resync          synchronous restart: clear the counters and start filling again
//   locked          1 while checking
//   bit_err         one-cycle pulse when the previous beat mismatched
//   err_count       saturating total of mismatches
//   hist_state      history register, bit 0 = newest
module lfsr_checker #(
  parameter int WIDTH      = 5,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] taps,
  lfsr_checker_if.slave    s,
  input  logic             resync,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] hist_state
);

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_CHECK = 1'b1;

  localparam int FC_W = $clog2(WIDTH + 1);
  localparam int MC_W = $clog2(ERR_THRESH + 1);
  localparam logic [FC_W-1:0] FILL_LAST = FC_W'(WIDTH - 1);
  localparam logic [MC_W-1:0] MISS_LAST = MC_W'(ERR_THRESH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] hist;
  logic [FC_W-1:0]  fill_cnt;
  logic [MC_W-1:0]  miss_cnt;

  logic             pred;
  logic             mismatch;
  logic [WIDTH-1:0] hist_fill;
  logic [WIDTH-1:0] hist_chk;

  assign pred      = ^(taps & hist);
  assign mismatch  = s.in_bit ^ pred;
  assign hist_fill = {hist[WIDTH-2:0], s.in_bit};
  // While checking, the reference runs free on its own prediction. A single
  // line error then yields exactly one bit_err and does not corrupt later predictions.
  assign hist_chk  = {hist[WIDTH-2:0], pred};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FILL;
      hist      <= '0;
      fill_cnt  <= '0;
      miss_cnt  <= '0;
      bit_err   <= 1'b0;
      err_count <= '0;
    end else if (resync) begin
      state     <= ST_FILL;
      hist      <= '0;
      fill_cnt  <= '0;
      miss_cnt  <= '0;
      bit_err   <= 1'b0;
      err_count <= '0;
    end else begin
      bit_err <= 1'b0;
      if (s.in_valid) begin
        if (state == ST_FILL) begin
          hist <= hist_fill;
          if (fill_cnt == FILL_LAST) begin
            fill_cnt <= '0;
            // An all-zero seed is the LFSR lock-up state. Refill instead of locking onto it.
            if (hist_fill != '0) begin
              state <= ST_CHECK;
            end
          end else begin
            fill_cnt <= fill_cnt + FC_W'(1);
          end
        end else begin
          hist <= hist_chk;
          if (mismatch) begin
            bit_err <= 1'b1;
            if (err_count != {CNT_W{1'b1}}) begin
              err_count <= err_count + CNT_W'(1);
            end
            if (miss_cnt == MISS_LAST) begin
              state    <= ST_FILL;
              fill_cnt <= '0;
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + MC_W'(1);
            end
          end else begin
            miss_cnt <= '0;
          end
        end
      end
    end
  end

  assign locked     = (state == ST_CHECK);
  assign hist_state = hist;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker. Two instances see the same stream: one with a
// 16-bit counter and one with a 3-bit counter, so that saturation can be observed.
module tb_lfsr_checker;

  localparam logic [4:0] TAPS = 5'b10100;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  taps;
  logic        resync;
  logic        locked, bit_err;
  logic [15:0] err_count;
  logic [4:0]  hist_state;
  logic        locked_s, bit_err_s;
  logic [2:0]  err_count_s;
  logic [4:0]  hist_s;

  lfsr_checker_if sif ();

  lfsr_checker #(.WIDTH(5), .ERR_THRESH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .taps(taps), .s(sif), .resync(resync),
    .locked(locked), .bit_err(bit_err), .err_count(err_count), .hist_state(hist_state)
  );

  lfsr_checker #(.WIDTH(5), .ERR_THRESH(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .taps(taps), .s(sif), .resync(resync),
    .locked(locked_s), .bit_err(bit_err_s), .err_count(err_count_s), .hist_state(hist_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lk;
    logic        be;
    logic [15:0] e16;
    logic [2:0]  e3;
    logic [4:0]  h;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model and generator state.
  logic [4:0] m_hist, g;
  int         m_fill, m_miss, m_err16, m_err3;
  logic       m_lock, m_berr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic m_clear();
    m_hist = '0; m_fill = 0; m_miss = 0; m_lock = 1'b0; m_berr = 1'b0;
    m_err16 = 0; m_err3 = 0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic rs);
    logic p;
    if (rs) begin
      m_clear();
    end else begin
      m_berr = 1'b0;
      if (v && !m_lock) begin
        m_hist = {m_hist[3:0], b};
        m_fill++;
        if (m_fill == 5) begin
          m_fill = 0;
          m_lock = (m_hist != 5'd0);
        end
      end else if (v) begin
        p = ^(TAPS & m_hist);
        m_hist = {m_hist[3:0], p};
        if (b != p) begin
          m_berr = 1'b1;
          if (m_err16 < 65535) m_err16++;
          if (m_err3 < 7) m_err3++;
          m_miss++;
          if (m_miss == 4) begin
            m_lock = 1'b0; m_miss = 0; m_fill = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
    end
  endtask

  // Drive one cycle, then queue the response expected on that edge.
  task automatic cyc(input logic v, input logic b, input logic rs);
    exp_t e;
    sif.in_valid = v;
    sif.in_bit   = b;
    resync       = rs;
    @(posedge clk);
    model_step(v, b, rs);
    e.lk  = m_lock;
    e.be  = m_berr;
    e.e16 = m_err16[15:0];
    e.e3  = m_err3[2:0];
    e.h   = m_hist;
    q.push_back(e);
    #1;
  endtask

  task automatic gen_beat(input logic flip);
    logic fb;
    fb = ^(TAPS & g);
    g  = {g[3:0], fb};
    cyc(1'b1, fb ^ flip, 1'b0);
  endtask

  // Monitor: every queued edge is compared at the following falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("sb_main", {6'd0, locked, bit_err, err_count, err_count_s, hist_state}, {6'd0, mon_e});
        chk("sb_small", {25'd0, locked_s, bit_err_s, hist_s}, {25'd0, mon_e.lk, mon_e.be, mon_e.h});
      end
    end
  end

  initial begin
    int nv;
    rst = 1'b0; resync = 1'b0; taps = TAPS;
    sif.in_valid = 1'b0; sif.in_bit = 1'b0;
    m_clear(); g = 5'b00001;
    #3;
    chk("reset_main", {locked, bit_err, err_count, hist_state}, 32'd0);
    chk("reset_small", {locked_s, bit_err_s, err_count_s, hist_s}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // 1: clean stream, seed 00001. The first five bits are 0,0,1,0,1.
    for (int i = 1; i <= 100; i++) begin
      gen_beat(1'b0);
      if (i == 4) chk("t1_unlocked_beat4", locked, 0);
      if (i == 5) begin
        chk("t1_locked_beat5", locked, 1);
        chk("t1_hist_beat5", hist_state, 5'b00101);
      end
    end
    chk("t1_err_count", err_count, 0);

    // 2: a single flip on beat 20.
    cyc(1'b0, 1'b0, 1'b1); g = 5'b00001;
    for (int i = 1; i <= 30; i++) begin
      gen_beat(i == 20);
      if (i == 20) chk("t2_bit_err_pulse", bit_err, 1);
      if (i == 21) chk("t2_bit_err_clear", bit_err, 0);
    end
    chk("t2_err_count", err_count, 1);
    chk("t2_still_locked", locked, 1);

    // 3: four consecutive errors drop lock. Five clean beats then relock.
    cyc(1'b0, 1'b0, 1'b1); g = 5'b00001;
    for (int i = 1; i <= 10; i++) gen_beat(1'b0);
    for (int i = 1; i <= 4; i++) gen_beat(1'b1);
    chk("t3_err_count4", err_count, 4);
    chk("t3_unlocked", locked, 0);
    for (int i = 1; i <= 4; i++) gen_beat(1'b0);
    chk("t3_unlocked_refill4", locked, 0);
    gen_beat(1'b0);
    chk("t3_relocked", locked, 1);
    for (int i = 1; i <= 10; i++) gen_beat(1'b0);
    chk("t3_err_kept", err_count, 4);

    // 4: an all-zero fill must not lock. A real sequence then locks after five beats.
    cyc(1'b0, 1'b0, 1'b1); g = 5'b00001;
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("t4_zero_unlocked", locked, 0);
    chk("t4_zero_hist", hist_state, 0);
    for (int i = 1; i <= 4; i++) gen_beat(1'b0);
    chk("t4_unlocked_beat4", locked, 0);
    gen_beat(1'b0);
    chk("t4_locked", locked, 1);
    chk("t4_hist_gen", hist_state, g);

    // 5: gaps in in_valid. History tracks the generator state once filled.
    cyc(1'b0, 1'b0, 1'b1); g = 5'b00001; nv = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        gen_beat(1'b0); nv++;
        if (nv >= 5) chk("t5_hist_gen", hist_state, g);
      end else begin
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    chk("t5_err_count", err_count, 0);

    // 6: ten spaced flips saturate the 3-bit counter. Then resync, then async reset.
    cyc(1'b0, 1'b0, 1'b1); g = 5'b00001;
    for (int i = 1; i <= 5; i++) gen_beat(1'b0);
    for (int k = 0; k < 10; k++) begin
      gen_beat(1'b1);
      if (k == 9) chk("t6_pulse_at_sat", bit_err_s, 1);
      for (int i = 0; i < 3; i++) gen_beat(1'b0);
    end
    chk("t6_err16", err_count, 10);
    chk("t6_err3_sat", err_count_s, 7);
    chk("t6_locked", locked, 1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t6_resync_err", {err_count, err_count_s}, 0);
    chk("t6_resync_unlocked", locked, 0);
    for (int i = 1; i <= 4; i++) gen_beat(1'b0);
    chk("t6_beat_discarded", locked, 0);
    gen_beat(1'b0);
    chk("t6_relocked", locked, 1);
    for (int i = 1; i <= 6; i++) gen_beat(i == 3);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_main", {locked, bit_err, err_count, hist_state}, 32'd0);
    chk("t6_async_small", {locked_s, bit_err_s, err_count_s, hist_s}, 32'd0);
    m_clear();
    #1 rst = 1'b1;
    for (int i = 1; i <= 4; i++) gen_beat(1'b0);
    chk("t6_post_rst_unlocked", locked, 0);
    gen_beat(1'b0);
    chk("t6_post_rst_locked", locked, 1);

    repeat (2) @(negedge clk);
    #1;
    chk("sb_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
